// File: rtl/inst_responder.sv
// Core-side responder: tracks controller instruction words and returns burst/load/exec/drain status.
// Optional protocol checker is built when PROTO_CHECK_EN is defined; otherwise proto_err is tied low.
module inst_responder #(
    parameter int Q_DEPTH     = 8,
    parameter int K_DEPTH     = 8,
    parameter int LD_CYCLES   = 9,
    parameter int EXEC_CYCLES = 8,
    parameter int OUT_LAT     = 4,
    parameter int P_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] inst,
    output logic        q_full,
    output logic        k_full,
    output logic        ld_done,
    output logic        exec_done,
    output logic        out_wr,
    output logic        p_full,
    output logic [2:0]  phase,
    output logic        proto_err
);

    // state | meaning
    // IDLE  | instruction bus quiet for two cycles
    // QW    | qmem write burst
    // KW    | kmem write burst
    // LD    | array load
    // EX    | execute
    // DRAIN | ofifo results pending
    // PW    | pmem write / ofifo read
    // SFP   | special-function control active
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QW    = 3'd1,
        KW    = 3'd2,
        LD    = 3'd3,
        EX    = 3'd4,
        DRAIN = 3'd5,
        PW    = 3'd6,
        SFP   = 3'd7
    } phase_t;

    localparam logic [4:0] Q_LIM   = 5'(Q_DEPTH);
    localparam logic [4:0] K_LIM   = 5'(K_DEPTH);
    localparam logic [4:0] P_LIM   = 5'(P_DEPTH);
    localparam logic [4:0] LD_LIM  = 5'(LD_CYCLES);
    localparam logic [4:0] EX_LIM  = 5'(EXEC_CYCLES);
    localparam logic [4:0] LAT_LD  = 5'(OUT_LAT);
    localparam logic [4:0] CNT_MAX = 5'd31;

    function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic [4:0] lim);
        return (v >= lim) ? v : v + 5'd1;
    endfunction

    // A rising write strobe restarts the burst with this cycle counted as word one.
    function automatic logic [4:0] burst_next(input logic [4:0] cnt, input logic wr,
                                              input logic rise, input logic [4:0] lim);
        if (rise)
            return 5'd1;
        else if (wr)
            return sat_inc(cnt, lim);
        else
            return cnt;
    endfunction

    logic [19:0] prev_inst;
    logic [4:0]  q_cnt, k_cnt, p_cnt, ld_cnt, ex_cnt, lat_cnt;
    logic [4:0]  q_cnt_nx, k_cnt_nx, p_cnt_nx, ld_cnt_nx, ex_cnt_nx, lat_cnt_nx;
    logic        q_rise, k_rise, p_wr, p_rise, ex_rise, ex_fall;
    logic        out_wr_nx, lat_done;
    phase_t      state, state_nx;
    logic        unused_bits;

    assign unused_bits = ^{inst[15:8], inst[5], inst[3], inst[1]};

    assign q_rise  = inst[4] & ~prev_inst[4];
    assign k_rise  = inst[2] & ~prev_inst[2];
    assign p_wr    = inst[0] & inst[16];
    assign p_rise  = p_wr & ~(prev_inst[0] & prev_inst[16]);
    assign ex_rise = inst[7] & ~prev_inst[7];
    assign ex_fall = ~inst[7] & prev_inst[7];

    assign q_cnt_nx  = burst_next(q_cnt, inst[4], q_rise, Q_LIM);
    assign k_cnt_nx  = burst_next(k_cnt, inst[2], k_rise, K_LIM);
    assign p_cnt_nx  = burst_next(p_cnt, p_wr, p_rise, P_LIM);
    assign ld_cnt_nx = inst[6] ? sat_inc(ld_cnt, CNT_MAX) : 5'd0;
    assign ex_cnt_nx = inst[7] ? sat_inc(ex_cnt, CNT_MAX) : 5'd0;

    always_comb begin
        lat_cnt_nx = lat_cnt;
        lat_done   = 1'b0;
        if (ex_rise) begin
            lat_cnt_nx = 5'd0;
        end else if (ex_fall) begin
            lat_cnt_nx = LAT_LD;
        end else if (lat_cnt != 5'd0) begin
            lat_cnt_nx = lat_cnt - 5'd1;
            lat_done   = (lat_cnt == 5'd1);
        end
        // ofifo read takes precedence over a countdown finishing in the same cycle
        if (inst[16])
            out_wr_nx = 1'b0;
        else if (lat_done)
            out_wr_nx = 1'b1;
        else
            out_wr_nx = out_wr;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_inst <= '0;
            q_cnt     <= '0;
            k_cnt     <= '0;
            p_cnt     <= '0;
            ld_cnt    <= '0;
            ex_cnt    <= '0;
            lat_cnt   <= '0;
            q_full    <= 1'b0;
            k_full    <= 1'b0;
            p_full    <= 1'b0;
            ld_done   <= 1'b0;
            exec_done <= 1'b0;
            out_wr    <= 1'b0;
        end else begin
            prev_inst <= inst;
            q_cnt     <= q_cnt_nx;
            k_cnt     <= k_cnt_nx;
            p_cnt     <= p_cnt_nx;
            ld_cnt    <= ld_cnt_nx;
            ex_cnt    <= ex_cnt_nx;
            lat_cnt   <= lat_cnt_nx;
            q_full    <= ~q_rise & (q_cnt_nx == Q_LIM);
            k_full    <= ~k_rise & (k_cnt_nx == K_LIM);
            p_full    <= ~p_rise & (p_cnt_nx == P_LIM);
            ld_done   <= inst[6] & (ld_cnt_nx >= LD_LIM);
            exec_done <= inst[7] & (ex_cnt_nx >= EX_LIM);
            out_wr    <= out_wr_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (inst == 20'd0 && prev_inst == 20'd0)
            state_nx = IDLE;
        else if (inst[19:17] != 3'd0)
            state_nx = SFP;
        else if (inst[16])
            state_nx = PW;
        else if (out_wr || lat_cnt != 5'd0)
            state_nx = DRAIN;
        else if (inst[7])
            state_nx = EX;
        else if (inst[6])
            state_nx = LD;
        else if (inst[2])
            state_nx = KW;
        else if (inst[4])
            state_nx = QW;
    end

    assign phase = state;

`ifdef PROTO_CHECK_EN
    logic [4:0] q_run;
    logic       viol;

    // q_run counts consecutive qmem write cycles independently of the burst counter
    always_comb begin
        viol = (inst[4] & inst[5]) | (inst[2] & inst[3]) | (inst[0] & inst[1]) |
               (inst[6] & inst[7]) |
               ((inst[19] & inst[18]) | (inst[19] & inst[17]) | (inst[18] & inst[17])) |
               (inst[4] & (q_run >= Q_LIM));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_run     <= '0;
            proto_err <= 1'b0;
        end else begin
            q_run     <= inst[4] ? sat_inc(q_run, CNT_MAX) : 5'd0;
            proto_err <= proto_err | viol;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_responder.sv
// Directed bench for inst_responder: expected values queued when stimulus is applied,
// popped and compared once the corresponding edge has been observed.
module tb_inst_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] inst;
    logic        q_full, k_full, ld_done, exec_done, out_wr, p_full, proto_err;
    logic [2:0]  phase;

    int n_tests = 0;
    int n_fail  = 0;

    string       exp_tag[$];
    logic [31:0] exp_val[$];

    inst_responder dut (
        .clk       (clk),
        .reset     (reset),
        .inst      (inst),
        .q_full    (q_full),
        .k_full    (k_full),
        .ld_done   (ld_done),
        .exec_done (exec_done),
        .out_wr    (out_wr),
        .p_full    (p_full),
        .phase     (phase),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] all_outs();
        return {22'd0, phase, q_full, k_full, ld_done, exec_done, out_wr, p_full, proto_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_tag.push_back(tag);
        exp_val.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] v;
        n_tests++;
        if (exp_val.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            tag = exp_tag.pop_front();
            v   = exp_val.pop_front();
            assert (obs === v) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, v);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        inst  = 20'hFFFFF;
        step();
        step();
        expect_val("reset_outs", 32'd0);
        chk(all_outs());
        reset = 1'b1;
        inst  = 20'd0;
        step();
        expect_val("idle_after_reset", 32'd0);
        chk(all_outs());

        // qmem burst, hold and restart
        inst = 20'h00010;
        repeat (7) step();
        expect_val("q_full_at_7", 32'd0);
        chk(32'(q_full));
        expect_val("q_phase", 32'd1);
        chk(32'(phase));
        step();
        expect_val("q_full_at_8", 32'd1);
        chk(32'(q_full));
        inst = 20'd0;
        step();
        expect_val("q_full_hold", 32'd1);
        chk(32'(q_full));
        inst = 20'h00010;
        step();
        expect_val("q_rise_clears", 32'd0);
        chk(32'(q_full));
        repeat (6) step();
        expect_val("q_restart_7", 32'd0);
        chk(32'(q_full));
        step();
        expect_val("q_restart_8", 32'd1);
        chk(32'(q_full));
        inst = 20'd0;
        step();
        step();
        expect_val("idle_two_zero", 32'd0);
        chk(32'(phase));

        // kmem burst
        inst = 20'h00004;
        repeat (8) step();
        expect_val("k_full", 32'd1);
        chk(32'(k_full));
        expect_val("k_phase", 32'd2);
        chk(32'(phase));
        inst = 20'd0;
        step();
        step();

        // array load
        inst = 20'h00040;
        for (int k = 1; k <= 12; k++) begin
            step();
            expect_val($sformatf("ld_done_%0d", k), 32'(k >= 9));
            chk(32'(ld_done));
        end
        expect_val("ld_phase", 32'd3);
        chk(32'(phase));
        inst = 20'd0;
        step();
        expect_val("ld_drop", 32'd0);
        chk(32'(ld_done));
        step();

        // execute then drain latency
        inst = 20'h00080;
        for (int k = 1; k <= 8; k++) begin
            step();
            expect_val($sformatf("exec_done_%0d", k), 32'(k == 8));
            chk(32'(exec_done));
        end
        expect_val("ex_phase", 32'd4);
        chk(32'(phase));
        inst = 20'd0;
        for (int k = 1; k <= 5; k++) begin
            step();
            expect_val($sformatf("out_wr_%0d", k), 32'(k == 5));
            chk(32'(out_wr));
        end
        inst = 20'h10000;
        step();
        expect_val("out_wr_clear", 32'd0);
        chk(32'(out_wr));
        expect_val("pw_phase", 32'd6);
        chk(32'(phase));

        // re-raised exec cancels the countdown
        inst = 20'h00080;
        step();
        step();
        inst = 20'd0;
        step();
        step();
        inst = 20'h00080;
        repeat (6) step();
        expect_val("cancel_out_wr", 32'd0);
        chk(32'(out_wr));
        inst = 20'd0;
        repeat (5) step();
        expect_val("recount_out_wr", 32'd1);
        chk(32'(out_wr));
        inst = 20'h10000;
        step();
        expect_val("recount_clear", 32'd0);
        chk(32'(out_wr));

        // pmem burst, pmem_wr without ofifo_rd ignored
        inst = 20'h10001;
        repeat (7) step();
        expect_val("p_full_at_7", 32'd0);
        chk(32'(p_full));
        step();
        expect_val("p_full_at_8", 32'd1);
        chk(32'(p_full));
        inst = 20'h00001;
        repeat (3) step();
        expect_val("p_full_unchanged", 32'd1);
        chk(32'(p_full));
        expect_val("hold_phase", 32'd6);
        chk(32'(phase));
        inst = 20'h20001;
        step();
        expect_val("sfp_phase", 32'd7);
        chk(32'(phase));
        expect_val("sfp_p_full", 32'd1);
        chk(32'(p_full));

        // reset mid-operation
        inst = 20'h00010;
        repeat (3) step();
        reset = 1'b0;
        step();
        expect_val("midop_reset", 32'd0);
        chk(all_outs());
        reset = 1'b1;
        inst  = 20'd0;
        step();

        // protocol violation: qmem read and write together
        inst = 20'h00030;
        step();
        inst = 20'd0;
        step();
        step();
`ifdef PROTO_CHECK_EN
        expect_val("proto_err_set", 32'd1);
        chk(32'(proto_err));
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        expect_val("proto_err_reset", 32'd0);
        chk(32'(proto_err));
`else
        expect_val("proto_err_tied", 32'd0);
        chk(32'(proto_err));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
